// File: rtl/mult_div_unit.sv
// -----------------------------------------------------------------------------
// mult_div_unit
//   Multi-cycle integer multiply / divide unit with architectural HI/LO
//   registers. Multiplies use shift-add and divides use restoring
//   shift-subtract. Both work on unsigned magnitudes, one step per clock.
//   A final FIX cycle applies the sign correction and writes HI/LO.
//
//   Optional build macro: MULT_DIV_FAST_MULT_EN
//     When defined, MULT/MULTU skip the iterative RUN phase and take their
//     product from a single-cycle multiplier in FIX. Divide timing is the
//     same in both builds.
//
// Ports
//   clock        : single clock, all state changes on the rising edge
//   reset_n      : asynchronous active-low reset
//   start        : begin the operation selected by op (sampled in IDLE only)
//   op           : 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   operand_a    : multiplicand / dividend
//   operand_b    : multiplier / divisor
//   mthi, mtlo   : write write_data into HI / LO (IDLE only, wins over start)
//   write_data   : data for mthi / mtlo
//   busy         : high while an operation is in progress
//   done         : one-cycle pulse marking the HI/LO update
//   hi, lo       : registered HI / LO
//   div_by_zero  : registered divide-by-zero flag, valid while done is high
// -----------------------------------------------------------------------------
module mult_div_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [1:0]            op,
  input  logic [DATA_WIDTH-1:0] operand_a,
  input  logic [DATA_WIDTH-1:0] operand_b,
  input  logic                  mthi,
  input  logic                  mtlo,
  input  logic [DATA_WIDTH-1:0] write_data,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] hi,
  output logic [DATA_WIDTH-1:0] lo,
  output logic                  div_by_zero
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(W - 1);
  localparam logic [CW-1:0] CNT_ONE   = {{(CW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  // Two's-complement magnitude; only negative values of signed ops are negated.
  function automatic logic [W-1:0] mag_of(input logic [W-1:0] v, input logic is_signed);
    return (is_signed && v[W-1]) ? -v : v;
  endfunction

  // Conditional negation of a single-width value.
  function automatic logic [W-1:0] neg_w(input logic [W-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  // Conditional negation of a double-width product.
  function automatic logic [2*W-1:0] neg_2w(input logic [2*W-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  // State and control
  state_t          r_state;
  state_t          w_next_state;
  logic [CW-1:0]   r_count;

  // Iteration datapath: r_acc is the upper product half / partial remainder,
  // r_q is the multiplier being consumed / quotient being built.
  logic [W-1:0]    r_acc;
  logic [W-1:0]    r_q;
  logic [W-1:0]    r_mag_x;      // |multiplicand| or |divisor|
  logic [W-1:0]    r_a;          // raw dividend, returned in HI on divide-by-zero
  logic            r_is_div;
  logic            r_neg_q;      // negate product / quotient
  logic            r_neg_r;      // negate remainder (dividend was negative)
  logic            r_b_zero;

  // Architectural outputs
  logic [W-1:0]    r_hi;
  logic [W-1:0]    r_lo;
  logic            r_busy;
  logic            r_done;
  logic            r_dbz;

  // Operand preparation at start
  logic            w_signed;
  logic [W-1:0]    w_abs_a;
  logic [W-1:0]    w_abs_b;

  // Step arithmetic
  logic [W:0]      w_mul_sum;
  logic [W:0]      w_div_shift;
  logic            w_div_ge;
  logic [W-1:0]    w_div_sub;

  // FIX results
  logic [2*W-1:0]  w_prod;
  logic [2*W-1:0]  w_prod_fixed;
  logic [W-1:0]    w_fix_hi;
  logic [W-1:0]    w_fix_lo;
  logic            w_fix_dbz;

  // Output-process controls
  logic            w_accept;
  logic            w_step;
  logic [W-1:0]    w_hi_nxt;
  logic [W-1:0]    w_lo_nxt;
  logic            w_done_nxt;
  logic            w_dbz_nxt;
  logic            w_busy_nxt;

  assign w_signed = ~op[0];
  assign w_abs_a  = mag_of(operand_a, w_signed);
  assign w_abs_b  = mag_of(operand_b, w_signed);

  // Shift-add: add the multiplicand when the current multiplier LSB is set,
  // then the whole {acc, q} pair shifts right by one.
  assign w_mul_sum = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_mag_x} : {(W+1){1'b0}});

  // Restoring divide: shift the next dividend bit into the partial remainder
  // and subtract when it fits. The true difference is below the divisor, so a
  // W-bit subtraction is exact.
  assign w_div_shift = {r_acc, r_q[W-1]};
  assign w_div_ge    = (w_div_shift >= {1'b0, r_mag_x});
  assign w_div_sub   = w_div_shift[W-1:0] - r_mag_x;

`ifdef MULT_DIV_FAST_MULT_EN
  assign w_prod = {{W{1'b0}}, r_mag_x} * {{W{1'b0}}, r_q};
`else
  assign w_prod = {r_acc, r_q};
`endif

  assign w_prod_fixed = neg_2w(w_prod, r_neg_q);

  assign busy        = r_busy;
  assign done        = r_done;
  assign hi          = r_hi;
  assign lo          = r_lo;
  assign div_by_zero = r_dbz;

  // FSM state register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FSM next-state logic; a move request in IDLE blocks start for that cycle
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (start && !mthi && !mtlo) begin
`ifdef MULT_DIV_FAST_MULT_EN
          if (!op[1]) begin
            w_next_state = S_FIX;
          end else begin
            w_next_state = S_RUN;
          end
`else
          w_next_state = S_RUN;
`endif
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_RUN: begin
        if (r_count == LAST_STEP) begin
          w_next_state = S_FIX;
        end else begin
          w_next_state = S_RUN;
        end
      end
      S_FIX:   w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // FIX-cycle results: sign correction and divide-by-zero substitution
  always_comb begin
    w_fix_hi  = r_hi;
    w_fix_lo  = r_lo;
    w_fix_dbz = 1'b0;
    if (r_is_div) begin
      if (r_b_zero) begin
        w_fix_lo  = {W{1'b1}};
        w_fix_hi  = r_a;
        w_fix_dbz = 1'b1;
      end else begin
        // Min-int / -1 needs no special case: the magnitude quotient is
        // already the min-int bit pattern and is not negated (same signs).
        w_fix_lo  = neg_w(r_q, r_neg_q);
        w_fix_hi  = neg_w(r_acc, r_neg_r);
        w_fix_dbz = 1'b0;
      end
    end else begin
      w_fix_hi  = w_prod_fixed[2*W-1:W];
      w_fix_lo  = w_prod_fixed[W-1:0];
      w_fix_dbz = 1'b0;
    end
  end

  // FSM output logic: datapath strobes and next values of the output registers
  always_comb begin
    w_accept   = 1'b0;
    w_step     = 1'b0;
    w_hi_nxt   = r_hi;
    w_lo_nxt   = r_lo;
    w_done_nxt = 1'b0;
    w_dbz_nxt  = 1'b0;
    w_busy_nxt = (w_next_state != S_IDLE);
    case (r_state)
      S_IDLE: begin
        if (mthi || mtlo) begin
          if (mthi) begin
            w_hi_nxt = write_data;
          end else begin
            w_hi_nxt = r_hi;
          end
          if (mtlo) begin
            w_lo_nxt = write_data;
          end else begin
            w_lo_nxt = r_lo;
          end
        end else if (start) begin
          w_accept = 1'b1;
        end else begin
          w_accept = 1'b0;
        end
      end
      S_RUN: begin
        w_step = 1'b1;
      end
      S_FIX: begin
        w_hi_nxt   = w_fix_hi;
        w_lo_nxt   = w_fix_lo;
        w_done_nxt = 1'b1;
        w_dbz_nxt  = w_fix_dbz;
      end
      default: begin
        w_accept = 1'b0;
      end
    endcase
  end

  // Iteration datapath: operand latch at accept, one step per RUN cycle
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_count  <= {CW{1'b0}};
      r_acc    <= {W{1'b0}};
      r_q      <= {W{1'b0}};
      r_mag_x  <= {W{1'b0}};
      r_a      <= {W{1'b0}};
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_b_zero <= 1'b0;
    end else if (w_accept) begin
      r_count  <= {CW{1'b0}};
      r_acc    <= {W{1'b0}};
      r_is_div <= op[1];
      r_mag_x  <= op[1] ? w_abs_b : w_abs_a;
      r_q      <= op[1] ? w_abs_a : w_abs_b;
      r_a      <= operand_a;
      r_neg_q  <= w_signed & (operand_a[W-1] ^ operand_b[W-1]);
      r_neg_r  <= w_signed & operand_a[W-1];
      r_b_zero <= (operand_b == {W{1'b0}});
    end else if (w_step) begin
      r_count <= r_count + CNT_ONE;
      if (r_is_div) begin
        r_acc <= w_div_ge ? w_div_sub : w_div_shift[W-1:0];
        r_q   <= {r_q[W-2:0], w_div_ge};
      end else begin
        r_acc <= w_mul_sum[W:1];
        r_q   <= {w_mul_sum[0], r_q[W-1:1]};
      end
    end
  end

  // Registered outputs: HI/LO, busy, done, div_by_zero
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_hi   <= {W{1'b0}};
      r_lo   <= {W{1'b0}};
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_dbz  <= 1'b0;
    end else begin
      r_hi   <= w_hi_nxt;
      r_lo   <= w_lo_nxt;
      r_busy <= w_busy_nxt;
      r_done <= w_done_nxt;
      r_dbz  <= w_dbz_nxt;
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
module tb_mult_div_unit;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

`ifdef MULT_DIV_FAST_MULT_EN
  localparam int MUL_LAT = 1;
  localparam int IGN_CYC = 1;
`else
  localparam int MUL_LAT = 33;
  localparam int IGN_CYC = 5;
`endif
  localparam int DIV_LAT = 33;

  logic        clock;
  logic        reset_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic        mthi;
  logic        mtlo;
  logic [31:0] write_data;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        div_by_zero;

  int n_cmp;
  int n_fail;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    logic        exp_dbz;
  } vec_t;

  vec_t vecs[13];

  mult_div_unit #(.DATA_WIDTH(32)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .start       (start),
    .op          (op),
    .operand_a   (operand_a),
    .operand_b   (operand_b),
    .mthi        (mthi),
    .mtlo        (mtlo),
    .write_data  (write_data),
    .busy        (busy),
    .done        (done),
    .hi          (hi),
    .lo          (lo),
    .div_by_zero (div_by_zero)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Issue one operation (call #1 after a rising edge); returns done latency in
  // edges after the start edge (0 on timeout) and number of busy cycles seen.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output int bcnt);
    start = 1'b1; op = o; operand_a = a; operand_b = b;
    @(posedge clock); #1;
    start = 1'b0;
    lat  = 0;
    bcnt = busy ? 1 : 0;
    for (int c = 1; c <= 100; c++) begin
      @(posedge clock); #1;
      if (done) begin
        lat = c;
        break;
      end
      if (busy) bcnt++;
    end
  endtask

  task automatic set_extra(input logic en);
    start      = en;
    mthi       = en;
    mtlo       = en;
    op         = OP_MULTU;
    operand_a  = 32'h0000_0002;
    operand_b  = 32'h0000_0003;
    write_data = en ? 32'hDEAD_BEEF : 32'h0000_0000;
  endtask

  initial begin
    int lat;
    int bcnt;
    int exp_lat;
    int n_done;
    n_cmp = 0; n_fail = 0;
    reset_n = 1'b0; start = 1'b0; op = 2'b00; operand_a = 32'h0; operand_b = 32'h0;
    mthi = 1'b0; mtlo = 1'b0; write_data = 32'h0;

    vecs[0]  = '{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
    vecs[1]  = '{OP_MULT,  32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0};
    vecs[2]  = '{OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
    vecs[3]  = '{OP_DIVU,  32'h0000_000A, 32'h0000_0000, 32'h0000_000A, 32'hFFFF_FFFF, 1'b1};
    vecs[4]  = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
    vecs[5]  = '{OP_MULTU, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, 1'b0};
    vecs[6]  = '{OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0};
    vecs[7]  = '{OP_DIVU,  32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E, 1'b0};
    vecs[8]  = '{OP_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0};
    vecs[9]  = '{OP_DIVU,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0};
    vecs[10] = '{OP_MULT,  32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 1'b0};
    vecs[11] = '{OP_DIV,   32'hFFFF_FFF8, 32'h0000_0000, 32'hFFFF_FFF8, 32'hFFFF_FFFF, 1'b1};
    vecs[12] = '{OP_DIVU,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000, 1'b0};

    // Reset state
    #1;
    check("reset_hi",   {32'h0, hi}, 64'h0);
    check("reset_lo",   {32'h0, lo}, 64'h0);
    check("reset_busy", {63'h0, busy}, 64'h0);
    check("reset_done", {63'h0, done}, 64'h0);
    check("reset_dbz",  {63'h0, div_by_zero}, 64'h0);
    @(negedge clock); reset_n = 1'b1;
    @(posedge clock); #1;

    // Table-driven operations
    for (int i = 0; i < 13; i++) begin
      exp_lat = vecs[i].op[1] ? DIV_LAT : MUL_LAT;
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, bcnt);
      check($sformatf("v%0d_latency", i), 64'(lat), 64'(exp_lat));
      check($sformatf("v%0d_busy_cycles", i), 64'(bcnt), 64'(exp_lat));
      check($sformatf("v%0d_hi", i), {32'h0, hi}, {32'h0, vecs[i].exp_hi});
      check($sformatf("v%0d_lo", i), {32'h0, lo}, {32'h0, vecs[i].exp_lo});
      check($sformatf("v%0d_dbz", i), {63'h0, div_by_zero}, {63'h0, vecs[i].exp_dbz});
      check($sformatf("v%0d_busy_at_done", i), {63'h0, busy}, 64'h0);
      @(posedge clock); #1;
      check($sformatf("v%0d_done_width", i), {63'h0, done}, 64'h0);
      check($sformatf("v%0d_dbz_width", i), {63'h0, div_by_zero}, 64'h0);
      check($sformatf("v%0d_hi_hold", i), {32'h0, hi}, {32'h0, vecs[i].exp_hi});
    end

    // mthi together with start in IDLE: move wins, start ignored
    mthi = 1'b1; write_data = 32'h1234_5678; start = 1'b1;
    op = OP_DIV; operand_a = 32'h0000_0064; operand_b = 32'h0000_0007;
    @(posedge clock); #1;
    check("mthi_hi", {32'h0, hi}, {32'h0, 32'h1234_5678});
    check("mthi_busy", {63'h0, busy}, 64'h0);
    mthi = 1'b0; start = 1'b0;
    @(posedge clock); #1;
    check("mthi_busy_after", {63'h0, busy}, 64'h0);
    check("mthi_done_after", {63'h0, done}, 64'h0);
    mthi = 1'b1; mtlo = 1'b1; write_data = 32'h55AA_55AA;
    @(posedge clock); #1;
    mthi = 1'b0; mtlo = 1'b0;
    check("both_hi", {32'h0, hi}, {32'h0, 32'h55AA_55AA});
    check("both_lo", {32'h0, lo}, {32'h0, 32'h55AA_55AA});

    // MULT with a second start (plus moves) while busy: single done
    start = 1'b1; op = OP_MULT; operand_a = 32'hFFFF_FFFD; operand_b = 32'h0000_0005;
    @(posedge clock); #1;
    start = 1'b0;
    set_extra(IGN_CYC == 1);
    n_done = 0;
    for (int c = 1; c <= 45; c++) begin
      @(posedge clock); #1;
      if (done) n_done++;
      if (c == IGN_CYC)
        check("busy_move_ignored_hi", {32'h0, hi},
              {32'h0, (IGN_CYC >= MUL_LAT) ? 32'hFFFF_FFFF : 32'h55AA_55AA});
      set_extra(c == IGN_CYC - 1);
    end
    set_extra(1'b0);
    check("second_start_done_count", 64'(n_done), 64'd1);
    check("second_start_hi", {32'h0, hi}, {32'h0, 32'hFFFF_FFFF});
    check("second_start_lo", {32'h0, lo}, {32'h0, 32'hFFFF_FFF1});
    check("second_start_busy", {63'h0, busy}, 64'h0);

    // DIV abandoned by reset at cycle 10
    start = 1'b1; op = OP_DIV; operand_a = 32'h0000_0064; operand_b = 32'h0000_0007;
    @(posedge clock); #1;
    start = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clock); #1;
    end
    check("mid_busy_before_reset", {63'h0, busy}, 64'h1);
    reset_n = 1'b0;
    #1;
    check("abort_hi", {32'h0, hi}, 64'h0);
    check("abort_lo", {32'h0, lo}, 64'h0);
    check("abort_busy", {63'h0, busy}, 64'h0);
    check("abort_done", {63'h0, done}, 64'h0);
    @(negedge clock); @(negedge clock);
    reset_n = 1'b1;
    n_done = 0;
    for (int c = 1; c <= 50; c++) begin
      @(posedge clock); #1;
      if (done) n_done++;
    end
    check("abort_no_done", 64'(n_done), 64'd0);
    check("abort_hi_later", {32'h0, hi}, 64'h0);
    check("abort_lo_later", {32'h0, lo}, 64'h0);

    // Start honoured at the first edge after reset release
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    run_op(OP_MULTU, 32'h0000_0003, 32'h0000_0004, lat, bcnt);
    check("post_reset_latency", 64'(lat), 64'(MUL_LAT));
    check("post_reset_lo", {32'h0, lo}, {32'h0, 32'h0000_000C});
    check("post_reset_hi", {32'h0, hi}, 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, giving the operand, HI and LO width.
REQ-002 The block SHALL have port clock, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port start, input, 1, request to begin the operation selected by op.
REQ-005 The block SHALL have port op, input, 2, operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 The block SHALL have ports operand_a and operand_b, input, DATA_WIDTH each: multiplicand/dividend and multiplier/divisor.
REQ-007 The block SHALL have ports mthi and mtlo, input, 1 each: write write_data into HI or LO.
REQ-008 The block SHALL have port write_data, input, DATA_WIDTH, data for mthi/mtlo.
REQ-009 The block SHALL have port busy, output, 1, high while an operation is in progress; the pipeline stalls on it.
REQ-010 The block SHALL have port done, output, 1, one-cycle pulse marking the HI/LO update.
REQ-011 The block SHALL have ports hi and lo, output, DATA_WIDTH each: registered HI/LO, feeding the write-back select mux.
REQ-012 The block SHALL have port div_by_zero, output, 1, registered flag, valid while done is high.

Function
REQ-013 The FSM SHALL have states IDLE, RUN and FIX; start is sampled only in IDLE.
REQ-014 Start sampled at edge E0 SHALL latch operands and op, go to RUN, and set busy at E0.
REQ-015 RUN SHALL last DATA_WIDTH cycles, with one shift-add (multiply) or one restoring shift-subtract (divide) step per cycle, on unsigned magnitudes.
REQ-016 FIX SHALL apply sign correction, write HI/LO and set done at edge E(DATA_WIDTH+1), clear busy at that same edge, and return to IDLE.
REQ-017 done SHALL be high for exactly one cycle and busy SHALL be high for exactly DATA_WIDTH+1 cycles per operation.
REQ-018 MULT/MULTU SHALL produce a 2*DATA_WIDTH product, with HI = upper half and LO = lower half.
REQ-019 For signed ops, magnitudes SHALL be taken as unsigned DATA_WIDTH values, so the magnitude of the minimum integer is 2^(DATA_WIDTH-1).
REQ-020 MULT SHALL negate the product when the operand signs differ.
REQ-021 DIV/DIVU SHALL produce LO = quotient and HI = remainder.
REQ-022 DIV SHALL negate the quotient when the operand signs differ, and the remainder SHALL take the dividend's sign.
REQ-023 For a divide with operand_b = 0, the block SHALL give LO = all ones, HI = operand_a, and div_by_zero = 1 with done; otherwise div_by_zero = 0.
REQ-024 Signed overflow (minimum integer / -1) SHALL give LO = minimum integer, HI = 0, and div_by_zero = 0.
REQ-025 start, mthi and mtlo while busy SHALL be ignored.
REQ-026 mthi/mtlo in IDLE SHALL update the register at the next edge, with no effect on busy or done.
REQ-027 If mthi or mtlo and start are asserted together in IDLE, the move SHALL win and start SHALL be ignored that cycle.
REQ-028 If mthi and mtlo are asserted together, both HI and LO SHALL be written.
REQ-029 hi and lo SHALL hold their values between updates.

Reset
REQ-030 When reset_n is low, the block SHALL immediately force state IDLE, busy = 0, done = 0, div_by_zero = 0, hi = 0 and lo = 0.
REQ-031 Reset during RUN/FIX SHALL abandon the operation, with no later HI/LO update or done pulse.
REQ-032 Reset release SHALL be taken at a clock edge, with start honoured from the first edge after release.

Configuration
REQ-033 With macro MULT_DIV_FAST_MULT_EN defined, MULT/MULTU SHALL bypass RUN: FIX at E1 writes HI/LO from a single-cycle multiplier, busy is high for 1 cycle, and done pulses after E1.
REQ-034 Without MULT_DIV_FAST_MULT_EN, multiply SHALL be iterative per REQ-015..017, and divide timing SHALL be identical in both builds.

Verification
REQ-035 The bench SHALL check: MULTU 0xFFFFFFFF x 0xFFFFFFFF -> HI = 0xFFFFFFFE, LO = 0x00000001, done 33 edges after the start edge (1 edge with fast multiply).
REQ-036 The bench SHALL check: MULT 0xFFFFFFFD x 0x00000005 -> HI = 0xFFFFFFFF, LO = 0xFFFFFFF1; a second start at cycle 5 is ignored and produces a single done.
REQ-037 The bench SHALL check: DIV 0xFFFFFFF9 / 0x00000002 -> LO = 0xFFFFFFFD, HI = 0xFFFFFFFF, div_by_zero = 0.
REQ-038 The bench SHALL check: DIVU 0x0000000A / 0 -> LO = 0xFFFFFFFF, HI = 0x0000000A, div_by_zero = 1 for exactly one cycle.
REQ-039 The bench SHALL check: DIV 0x80000000 / 0xFFFFFFFF -> LO = 0x80000000, HI = 0x00000000.
REQ-040 The bench SHALL check: mthi 0x12345678 with start in IDLE -> HI = 0x12345678 and busy stays 0; then DIV started and reset_n pulled low at cycle 10 -> hi = lo = 0, busy = 0, and no done afterward.
